rf_bank_arbiter: RTL

- Per-cycle scheduler for the 4-bank operand register file.
- Arbitrates between NUM_OC operand collectors issuing single-source read requests and one writeback port. Each bank gets at most one access per cycle.
- Drives registered bank row, write-enable and collector-ID commands to the request FIFOs / banks.
- Tracks read-return timing so each collector knows when its operand arrives.

---
 rtl/rf_bank_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rf_bank_arbiter.sv
// rf_bank_arbiter: per-cycle 4-bank register file scheduler (writeback vs. operand collector reads) with read-return tracking.
// Optional RF_ARB_STATS_EN adds per-bank conflict counters with stats_clr.
module rf_bank_arbiter #(
  parameter int NUM_OC     = 4,
  parameter int ROW_W      = 3,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_OC-1:0]       oc_req_valid,
  input  logic [2*NUM_OC-1:0]     oc_req_bank,
  input  logic [ROW_W*NUM_OC-1:0] oc_req_row,
  output logic [NUM_OC-1:0]       oc_gnt,
  input  logic                    wb_valid,
  input  logic [1:0]              wb_bank,
  input  logic [ROW_W-1:0]        wb_row,
  output logic                    wb_ready,
  output logic [3:0]              bank_en,
  output logic [3:0]              bank_wr,
  output logic [4*ROW_W-1:0]      bank_row,
  output logic [11:0]             bank_ocid,
  output logic [NUM_OC-1:0]       rd_ret_valid,
  output logic [2*NUM_OC-1:0]     rd_ret_bank
`ifdef RF_ARB_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [63:0]             bank_conflict_cnt
`endif
);
  localparam int PW = NUM_OC > 1 ? $clog2(NUM_OC) : 1;

  logic [PW-1:0]     r_rr     [4];
  logic [3:0]        r_starve [4];
  logic              r_pv     [4][RD_LAT];
  logic [2:0]        r_po     [4][RD_LAT];
  logic [NUM_OC-1:0] w_cand   [4];
  logic [PW-1:0]     w_sel    [4];
  logic [3:0]        w_wb_c, w_any_rd, w_wb_win, w_rd_win;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      logic found;
      int   k;
      found       = 1'b0;
      w_sel[b]    = '0;
      w_wb_c[b]   = wb_valid && wb_bank == 2'(b);
      for (int i = 0; i < NUM_OC; i++)
        w_cand[b][i] = oc_req_valid[i] && oc_req_bank[2*i +: 2] == 2'(b);
      w_any_rd[b] = |w_cand[b];
      // round-robin search starting at this bank's pointer
      for (int j = 0; j < NUM_OC; j++) begin
        k = int'(r_rr[b]) + j;
        if (k >= NUM_OC) k = k - NUM_OC;
        if (!found && w_cand[b][k]) begin
          w_sel[b] = PW'(k);
          found    = 1'b1;
        end
      end
      w_wb_win[b] = w_wb_c[b] && !(r_starve[b] == 4'(STARVE_LIM) && w_any_rd[b]);
      w_rd_win[b] = w_any_rd[b] && !w_wb_win[b];
    end
  end

  always_comb begin
    oc_gnt = '0;
    for (int i = 0; i < NUM_OC; i++)
      oc_gnt[i] = !rst && oc_req_valid[i] && w_rd_win[oc_req_bank[2*i +: 2]]
                  && w_sel[oc_req_bank[2*i +: 2]] == PW'(i);
    wb_ready = !rst && wb_valid && w_wb_win[wb_bank];
  end

  always_comb begin
    rd_ret_valid = '0;
    rd_ret_bank  = '0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < NUM_OC; i++)
        if (r_pv[b][RD_LAT-1] && r_po[b][RD_LAT-1] == 3'(i)) begin
          rd_ret_valid[i]       = 1'b1;
          rd_ret_bank[2*i +: 2] = 2'(b);
        end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_en   <= '0;
      bank_wr   <= '0;
      bank_row  <= '0;
      bank_ocid <= '0;
      for (int b = 0; b < 4; b++) begin
        r_rr[b]     <= '0;
        r_starve[b] <= '0;
        for (int s = 0; s < RD_LAT; s++) begin
          r_pv[b][s] <= 1'b0;
          r_po[b][s] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        bank_en[b] <= w_wb_win[b] | w_rd_win[b];
        if (w_wb_win[b]) begin
          bank_wr[b]               <= 1'b1;
          bank_row[ROW_W*b +: ROW_W] <= wb_row;
          bank_ocid[3*b +: 3]      <= '0;
        end else if (w_rd_win[b]) begin
          bank_wr[b]               <= 1'b0;
          bank_row[ROW_W*b +: ROW_W] <= oc_req_row[ROW_W*w_sel[b] +: ROW_W];
          bank_ocid[3*b +: 3]      <= 3'(w_sel[b]);
          r_rr[b]                  <= int'(w_sel[b]) == NUM_OC-1 ? '0 : w_sel[b] + PW'(1);
        end
        r_starve[b] <= (w_any_rd[b] && w_wb_win[b])
                       ? (r_starve[b] == 4'(STARVE_LIM) ? r_starve[b] : r_starve[b] + 4'd1) : 4'd0;
        // return pipeline is fed by the issued command, so data lands RD_LAT after bank_en
        r_pv[b][0] <= bank_en[b] & ~bank_wr[b];
        r_po[b][0] <= bank_ocid[3*b +: 3];
        for (int s = 1; s < RD_LAT; s++) begin
          r_pv[b][s] <= r_pv[b][s-1];
          r_po[b][s] <= r_po[b][s-1];
        end
      end
    end
  end

`ifdef RF_ARB_STATS_EN
  logic [3:0] w_conf;

  always_comb
    for (int b = 0; b < 4; b++)
      w_conf[b] = ($countones(w_cand[b]) + int'(w_wb_c[b])) > 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bank_conflict_cnt <= '0;
    else
      for (int b = 0; b < 4; b++)
        if (stats_clr) bank_conflict_cnt[16*b +: 16] <= '0;
        else if (w_conf[b] && bank_conflict_cnt[16*b +: 16] != 16'hFFFF)
          bank_conflict_cnt[16*b +: 16] <= bank_conflict_cnt[16*b +: 16] + 16'd1;
  end
`endif
endmodule
